cpu_alu: RTL and testbench
==========================

// Module: cpu_alu
// PURPOSE
//  Arithmetic stage directly downstream of the CPU register file. Consumes the A/B register
//  taps, executes one operation per start request and holds the result in an internal
//  result register. Drives the result onto the shared 8-bit data bus when enabled.
//  Keeps a Z/C/N flags register for the control unit's conditional jumps.
//  Single-cycle logic ops; a multi-cycle shift-add multiply exists when compiled in.
// PARAMETERS
//  WIDTH      8   datapath width (bus, operands, result)
//  MUL_CYCLES 8   multiply iterations; must equal WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  rega       in   WIDTH  operand A (register 0 tap)
//  regb       in   WIDTH  operand B (register 1 tap)
//  op         in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC A, 6 DEC A, 7 MUL/NOT
//  start      in   1      request; sampled on rising clk edge only when busy=0
//  result_oe  in   1      drive result onto data_out
//  busy       out  1      multiply in progress
//  done       out  1      one-cycle pulse: result and flags have just been written
//  data_out   out  WIDTH  result when result_oe=1, else 'bz
//  flags      out  3      {N,C,Z}, registered
// BEHAVIOUR
//  Reset: state=IDLE, result=0, flags=0, busy=0, done=0. data_out follows result_oe (0 or 'bz).
//  Reset mid-multiply aborts it; no done pulse is produced.
//  Operand capture: rega, regb and op are registered on the accepting edge.
//  Later changes to the register file do not affect an operation in flight.
//  Single-cycle ops (0-6, and 7 without the optional feature):
//   - On the edge that samples start=1, result and flags are written.
//   - done=1 for exactly the following cycle. busy stays 0.
//   - Back-to-back start on consecutive cycles is legal, one result per cycle.
//  Arithmetic: internal WIDTH+1-bit sum. ADD C=carry out. SUB=A+~B+1, so C=1 means no borrow (A>=B).
//  INC/DEC use B=1 with the same rules. AND/OR/XOR/NOT force C=0.
//  Z = (result==0). N = result[WIDTH-1]. All three flags update on every completed op.
//  Wrap-around: ADD FF+01 -> 00, C=1, Z=1. DEC 00 -> FF, C=0, N=1.
//  FSM: IDLE -> MUL on start with op=7; MUL -> IDLE after MUL_CYCLES iterations; else stays IDLE.
//  MUL: iteration counter 0..MUL_CYCLES-1. busy=1 from the cycle after acceptance until the final edge.
//   - On the final edge: result=low byte of A*B; C=1 if high byte !=0; Z/N from the low byte.
//   - done pulses in the next cycle. Total latency is MUL_CYCLES edges from acceptance to write.
//  start while busy=1 is ignored and not queued.
//  A start in the done cycle is accepted normally.
//  result_oe is purely combinational. During MUL the bus shows the previous result.
// CONFIGURATION
//  CPU_ALU_MUL_EN defined: op 7 = MUL. FSM MUL state and cpu_alu_mul are instantiated.
//  CPU_ALU_MUL_EN undefined: op 7 = NOT A, single-cycle. busy is tied 0. No MUL state or sub-module.
// STRUCTURE
//  cpu_alu_pkg holds the op encodings (OP_ADD..OP_MUL), the flag bit indices (FLAG_Z=0,
//  FLAG_C=1, FLAG_N=2) and the FSM state encodings. It is shared with the control unit.
//  Sub-module cpu_alu_mul: shift-add multiplier with load/step/last ports, WIDTH-bit operands,
//  2*WIDTH-bit product. It exists only under CPU_ALU_MUL_EN.
// TESTING
//  1. Reset with result_oe=1 -> data_out=00, flags=000, busy=0.
//     Release with result_oe=0 -> data_out='bz.
//  2. A=FF, B=01, ADD, start -> next cycle done=1, result=00, flags Z=1 C=1 N=0.
//  3. A=05, B=07, SUB -> result=FE, C=0, N=1, Z=0.
//     Then A=07, B=07, SUB -> result=00, C=1, Z=1.
//  4. MUL_EN: A=0C, B=0D, MUL -> busy high 8 cycles, result=9C, C=0.
//     A=10, B=10 -> result=00, C=1, Z=1.
//     Change rega mid-op -> same result.
//  5. MUL_EN: start pulsed while busy -> ignored, a single done pulse.
//     Assert reset_n=0 at iteration 4 -> busy=0, result=00, no done.
//  6. No MUL_EN: A=5A, op 7 -> result=A5, N=1, busy stays 0.
//     Back-to-back ADD, XOR starts -> two consecutive done pulses.

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: op encodings, flag bit indices and FSM state encodings
// shared between the ALU and the control unit.
package cpu_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  function automatic logic [2:0] pack_flags(
    input logic n,
    input logic c,
    input logic z
  );
    logic [2:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/cpu_alu_mul.sv
// cpu_alu_mul: shift-add multiplier, one partial product per step.
// Ports: load (capture a/b), step, last (final step), product (2*WIDTH).
module cpu_alu_mul
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;

  // product includes the current step, so it is final during the last step
  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (step && !last) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/cpu_alu.sv
// cpu_alu: ALU stage after the register file; result/flags registers,
// tri-state bus drive. Optional multiply under CPU_ALU_MUL_EN.
module cpu_alu
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] rega,
  input  logic [WIDTH-1:0] regb,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             result_oe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic [2:0]       flags
);

  logic [WIDTH-1:0] result;
  logic             accept;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             wr;
  logic [WIDTH-1:0] wr_res;
  logic [2:0]       wr_flags;

  assign accept = start & ~busy;

  // SUB and DEC add the inverted operand plus one
  always_comb begin
    opb = regb;
    cin = 1'b0;
    unique case (1'b1)
      (op == OP_SUB): begin
        opb = ~regb;
        cin = 1'b1;
      end
      (op == OP_INC): begin
        opb = WIDTH'(1);
      end
      (op == OP_DEC): begin
        opb = ~WIDTH'(1);
        cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, rega} + {1'b0, opb}
             + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_res = sum[WIDTH-1:0];
    alu_c   = sum[WIDTH];
    unique case (op)
      OP_AND: begin
        alu_res = rega & regb;
        alu_c   = 1'b0;
      end
      OP_OR: begin
        alu_res = rega | regb;
        alu_c   = 1'b0;
      end
      OP_XOR: begin
        alu_res = rega ^ regb;
        alu_c   = 1'b0;
      end
      OP_NOT: begin
        alu_res = ~rega;
        alu_c   = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef CPU_ALU_MUL_EN
  localparam int CW =
    (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_mul;
  logic               mul_last;
  logic               mul_fin;
  logic [2*WIDTH-1:0] product;

  assign is_mul   = (op == OP_MUL);
  assign busy     = (state == ST_MUL);
  assign mul_last = (cnt == CW'(MUL_CYCLES - 1));
  assign mul_fin  = busy & mul_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept && is_mul) begin
            state <= ST_MUL;
            cnt   <= '0;
          end
        end
        ST_MUL: begin
          if (mul_last) state <= ST_IDLE;
          else          cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cpu_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (accept & is_mul),
    .step   (busy),
    .last   (mul_last),
    .a      (rega),
    .b      (regb),
    .product(product)
  );

  always_comb begin
    wr       = mul_fin | (accept & ~is_mul);
    wr_res   = alu_res;
    wr_flags = pack_flags(alu_res[WIDTH-1], alu_c,
                          alu_res == '0);
    if (mul_fin) begin
      wr_res   = product[WIDTH-1:0];
      wr_flags = pack_flags(
        product[WIDTH-1],
        |product[2*WIDTH-1:WIDTH],
        product[WIDTH-1:0] == '0);
    end
  end
`else
  logic [MUL_CYCLES-1:0] unused_mul_cycles;
  assign unused_mul_cycles = '0;
  assign busy = 1'b0;

  always_comb begin
    wr       = accept;
    wr_res   = alu_res;
    wr_flags = pack_flags(alu_res[WIDTH-1], alu_c,
                          alu_res == '0);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
    end else begin
      done <= wr;
      if (wr) begin
        result <= wr_res;
        flags  <= wr_flags;
      end
    end
  end

  assign data_out = result_oe ? result : 'z;

endmodule

// File: tb/tb_cpu_alu.sv
// tb_cpu_alu: randomized scoreboard bench for cpu_alu.
// Handles both CPU_ALU_MUL_EN builds.
module tb_cpu_alu;

  logic       clk;
  logic       reset_n;
  logic [7:0] rega;
  logic [7:0] regb;
  logic [2:0] op;
  logic       start;
  logic       result_oe;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
  logic [2:0] flags;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [10:0] sb[$];
  logic [10:0] e;

  cpu_alu #(.WIDTH(8), .MUL_CYCLES(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rega     (rega),
    .regb     (regb),
    .op       (op),
    .start    (start),
    .result_oe(result_oe),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .flags    (flags)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // reference: plain integer arithmetic, {N,C,Z,result}
  function automatic logic [10:0] model(
    input int o, input int a, input int b);
    int r;
    bit c;
    r = 0;
    c = 0;
    case (o)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = a - b; c = (a >= b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a + 1; c = (r > 255); end
      6: begin r = a - 1; c = (a >= 1); end
      default: begin
`ifdef CPU_ALU_MUL_EN
        r = a * b;
        c = (r > 255);
`else
        r = 255 - a;
`endif
      end
    endcase
    r = r & 255;
    return {r >= 128, c, r == 0, 8'(r)};
  endfunction

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got %0h want none",
                 data_out);
      end else begin
        e = sb.pop_front();
        chk("result", data_out, e[7:0]);
        chk("flags", flags, e[10:8]);
`ifndef CPU_ALU_MUL_EN
        chk("busy_tied", busy, 0);
`endif
      end
      done_cnt++;
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [10:0] x);
    @(posedge clk);
    #2;
    op = o;
    rega = a;
    regb = b;
    start = 1;
    sb.push_back(x);
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    start = 0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // returns on the negedge showing done
  task automatic wait_mul(input bit poke,
                          output int bc);
    bit seen;
    bc = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) seen = 1;
      if (poke && i == 3) begin
        rega = ~rega;
        op = 3'd0;
        start = 1;
      end
      if (poke && i == 4) start = 0;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL mul_timeout: got no done want done");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int bc;
    int o;
    logic [7:0] a, b;
    reset_n = 0;
    result_oe = 1;
    start = 0;
    op = 0;
    rega = 0;
    regb = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", data_out, 8'h00);
    chk("rst_flags", flags, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    result_oe = 0;
    #1;
    chk("rst_bus_z", data_out === 8'hzz, 1);
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("rel_bus_z", data_out === 8'hzz, 1);
    result_oe = 1;

    issue(3'd0, 8'hFF, 8'h01, {3'b011, 8'h00});
    idle();
    issue(3'd1, 8'h05, 8'h07, {3'b100, 8'hFE});
    issue(3'd1, 8'h07, 8'h07, {3'b011, 8'h00});
    issue(3'd6, 8'h00, 8'h33, {3'b100, 8'hFF});
    idle();
    settle();

    c0 = done_cnt;
    issue(3'd0, 8'h10, 8'h20, {3'b000, 8'h30});
    issue(3'd4, 8'hF0, 8'h0F, {3'b100, 8'hFF});
    idle();
    @(negedge clk);
    #1;
    chk("b2b_dones", done_cnt - c0, 2);
    settle();

`ifdef CPU_ALU_MUL_EN
    c0 = done_cnt;
    issue(3'd7, 8'h0C, 8'h0D, {3'b100, 8'h9C});
    idle();
    wait_mul(1, bc);
    chk("mul_busy_cycles", bc, 8);
    settle();
    chk("mul_one_done", done_cnt - c0, 1);

    issue(3'd7, 8'h10, 8'h10, {3'b011, 8'h00});
    idle();
    wait_mul(0, bc);
    chk("mul_busy_cycles2", bc, 8);
    rega = 8'h01;
    regb = 8'h02;
    op = 3'd0;
    start = 1;
    sb.push_back({3'b000, 8'h03});
    @(posedge clk);
    #2;
    start = 0;
    settle();

    c0 = done_cnt;
    issue(3'd7, 8'h0B, 8'h0E, 11'h0);
    idle();
    repeat (4) @(negedge clk);
    reset_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_bus", data_out, 8'h00);
    chk("abort_flags", flags, 3'b000);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (12) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - c0, 0);
`else
    issue(3'd7, 8'h5A, 8'h00, {3'b100, 8'hA5});
    idle();
    @(negedge clk);
    #1;
    chk("not_busy", busy, 0);
    settle();
`endif

    for (int i = 0; i < 150; i++) begin
      o = int'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      issue(3'(o), a, b, model(o, a, b));
`ifdef CPU_ALU_MUL_EN
      if (o == 7) begin
        idle();
        wait_mul(($urandom & 1) == 1, bc);
        chk("rnd_busy_cycles", bc, 8);
      end else if ($urandom_range(0, 2) == 0) begin
        idle();
      end
`else
      if ($urandom_range(0, 2) == 0) idle();
`endif
    end
    idle();
    repeat (5) @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
